// File: rtl/reset_sequencer.sv
// Reset bring-up: synchronise lock/button, debounce button, qualify lock, then
// release NUM_CH domains in order. Define RESET_SEQ_CAUSE_EN for the sticky cause port.
module reset_sequencer #(
    parameter int NUM_CH      = 3,
    parameter int STAGGER     = 16,
    parameter int LOCK_STABLE = 1024,
    parameter int DEBOUNCE    = 4096,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lock_in,
    input  logic              button_n,
    output logic [NUM_CH-1:0] reset_out,
    output logic              ready
`ifdef RESET_SEQ_CAUSE_EN
    ,
    output logic [1:0]        cause
`endif
);

    // state       | meaning
    // S_HOLD      | all domains held in reset, waiting for fault to clear
    // S_WAIT_LOCK | counting LOCK_STABLE clean cycles
    // S_STAGGER   | releasing domains one per STAGGER cycles
    // S_RUN       | all domains released
    typedef enum logic [1:0] {
        S_HOLD,
        S_WAIT_LOCK,
        S_STAGGER,
        S_RUN
    } state_t;

    localparam int LS_W  = (LOCK_STABLE > 1) ? $clog2(LOCK_STABLE) : 1;
    localparam int ST_W  = (STAGGER > 1) ? $clog2(STAGGER) : 1;
    localparam int CNT_W = (LS_W > ST_W) ? LS_W : ST_W;
    localparam int DB_W  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [CNT_W-1:0] LS_LAST  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] ST_LAST  = CNT_W'(STAGGER - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CH - 1);

    logic [SYNC_STAGES-1:0] lock_sync;
    logic [SYNC_STAGES-1:0] btn_sync;
    logic                   lock_s;
    logic                   btn_s;
    logic                   btn_db;
    logic [DB_W-1:0]        db_cnt;
    logic                   fault;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NUM_CH-1:0]  rst_q, rst_d;
    logic               ready_q, ready_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_sync <= '0;
            btn_sync  <= '1;
        end else begin
            lock_sync <= {lock_sync[SYNC_STAGES-2:0], lock_in};
            btn_sync  <= {btn_sync[SYNC_STAGES-2:0], button_n};
        end
    end

    assign lock_s = lock_sync[SYNC_STAGES-1];
    assign btn_s  = btn_sync[SYNC_STAGES-1];

    // The debounced state only flips after DEBOUNCE consecutive differing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_db <= 1'b1;
            db_cnt <= '0;
        end else if (btn_s == btn_db) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            btn_db <= btn_s;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    assign fault = !lock_s || !btn_db;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_HOLD;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_q   <= '1;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rst_q   <= rst_d;
            ready_q <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rst_d   = rst_q;
        ready_d = ready_q;
        case (state_q)
            S_HOLD: begin
                rst_d   = '1;
                ready_d = 1'b0;
                if (!fault) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            S_WAIT_LOCK: begin
                if (fault) begin
                    state_d = S_HOLD;
                end else if (cnt_q == LS_LAST) begin
                    state_d = S_STAGGER;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STAGGER: begin
                if (fault) begin
                    state_d = S_HOLD;
                    rst_d   = '1;
                end else if (cnt_q == ST_LAST) begin
                    cnt_d = '0;
                    for (int k = 0; k < NUM_CH; k++) begin
                        if (idx_q == IDX_W'(k)) rst_d[k] = 1'b0;
                    end
                    if (idx_q == IDX_LAST) begin
                        state_d = S_RUN;
                        ready_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                if (fault) begin
                    state_d = S_HOLD;
                    rst_d   = '1;
                    ready_d = 1'b0;
                end
            end
            default: begin
                state_d = S_HOLD;
                rst_d   = '1;
                ready_d = 1'b0;
            end
        endcase
    end

    assign reset_out = rst_q;
    assign ready     = ready_q;

`ifdef RESET_SEQ_CAUSE_EN
    logic [1:0] cause_q;

    // Only faults that knock a live sequence back into HOLD are recorded.
    always_ff @(posedge clk) begin
        if (reset) begin
            cause_q <= 2'b00;
        end else if (fault && (state_q != S_HOLD)) begin
            cause_q <= cause_q | {!btn_db, !lock_s};
        end
    end

    assign cause = cause_q;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed bring-up/fault scenarios with literal timing
// pins, then randomized lock/button/reset activity against a cycle-count model.
module tb_reset_sequencer;

    localparam int NCH = 3;
    localparam int ST  = 4;
    localparam int LS  = 8;
    localparam int DB  = 16;
    localparam int SS  = 2;

    logic           clk;
    logic           reset;
    logic           lock_in;
    logic           button_n;
    logic [NCH-1:0] reset_out;
    logic           ready;
    logic [0:0]     reset_out2;
    logic           ready2;
`ifdef RESET_SEQ_CAUSE_EN
    logic [1:0]     cause;
    logic [1:0]     cause2;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // model: n counts consecutive fault-free edges since the last HOLD entry
    int         m_n;
    logic [1:0] m_cause;
    bit         m_btn_db;
    int         m_db_run;
    bit         m_lock_hist[$];
    bit         m_btn_hist[$];

    reset_sequencer #(
        .NUM_CH(NCH), .STAGGER(ST), .LOCK_STABLE(LS), .DEBOUNCE(DB), .SYNC_STAGES(SS)
    ) dut (
        .clk(clk), .reset(reset), .lock_in(lock_in), .button_n(button_n),
        .reset_out(reset_out), .ready(ready)
`ifdef RESET_SEQ_CAUSE_EN
        , .cause(cause)
`endif
    );

    reset_sequencer #(
        .NUM_CH(1), .STAGGER(1), .LOCK_STABLE(LS), .DEBOUNCE(DB), .SYNC_STAGES(SS)
    ) dut1 (
        .clk(clk), .reset(reset), .lock_in(lock_in), .button_n(button_n),
        .reset_out(reset_out2), .ready(ready2)
`ifdef RESET_SEQ_CAUSE_EN
        , .cause(cause2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int exp_rst(int n, int nch, int st);
        int v = 0;
        for (int k = 0; k < nch; k++) begin
            if (n < 1 + LS + (k + 1) * st) v = v | (1 << k);
        end
        return v;
    endfunction

    function automatic int exp_ready(int n, int nch, int st);
        return (n >= 1 + LS + nch * st) ? 1 : 0;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit lk, bs, bt;
        lk = m_lock_hist[$];
        bs = m_btn_hist[$];
        bt = m_btn_db;
        if (reset) begin
            m_n = 0;
            m_cause = 2'b00;
            m_btn_db = 1'b1;
            m_db_run = 0;
            m_lock_hist = {};
            m_btn_hist = {};
            repeat (SS) begin
                m_lock_hist.push_back(1'b0);
                m_btn_hist.push_back(1'b1);
            end
        end else begin
            if (!lk || !bt) begin
                if (m_n > 0) m_cause = m_cause | {!bt, !lk};
                m_n = 0;
            end else if (m_n < 100000) begin
                m_n++;
            end
            if (bs != m_btn_db) begin
                m_db_run++;
                if (m_db_run == DB) begin
                    m_btn_db = bs;
                    m_db_run = 0;
                end
            end else begin
                m_db_run = 0;
            end
            m_lock_hist.push_front(lock_in);
            void'(m_lock_hist.pop_back());
            m_btn_hist.push_front(button_n);
            void'(m_btn_hist.pop_back());
        end
    endtask

    task automatic compare_all();
        chk("model_reset_out", 32'(reset_out), 32'(exp_rst(m_n, NCH, ST)));
        chk("model_ready", 32'(ready), 32'(exp_ready(m_n, NCH, ST)));
        chk("model_reset_out_1ch", 32'(reset_out2), 32'(exp_rst(m_n, 1, 1)));
        chk("model_ready_1ch", 32'(ready2), 32'(exp_ready(m_n, 1, 1)));
`ifdef RESET_SEQ_CAUSE_EN
        chk("model_cause", 32'(cause), 32'(m_cause));
        chk("model_cause_1ch", 32'(cause2), 32'(m_cause));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    // Caller starts with FSM in HOLD and lock chain low, then raises lock (edge 1 next).
    task automatic bringup_check();
        for (int e = 1; e <= 23; e++) begin
            tick();
            case (e)
                11: begin
                    chk("lit_1ch_pre", 32'(reset_out2), 32'd1);
                    chk("lit_1ch_rdy_pre", 32'(ready2), 32'd0);
                end
                12: begin
                    chk("lit_1ch_rel", 32'(reset_out2), 32'd0);
                    chk("lit_1ch_rdy", 32'(ready2), 32'd1);
                end
                14: chk("lit_e14", 32'(reset_out), 32'b111);
                15: chk("lit_e15", 32'(reset_out), 32'b110);
                18: chk("lit_e18", 32'(reset_out), 32'b110);
                19: chk("lit_e19", 32'(reset_out), 32'b100);
                22: begin
                    chk("lit_e22", 32'(reset_out), 32'b100);
                    chk("lit_e22_rdy", 32'(ready), 32'd0);
                end
                23: begin
                    chk("lit_e23", 32'(reset_out), 32'b000);
                    chk("lit_e23_rdy", 32'(ready), 32'd1);
                end
                default: ;
            endcase
        end
    endtask

    initial begin
        int lock_rate, btn_rate;
        reset = 1'b1;
        lock_in = 1'b0;
        button_n = 1'b1;
        m_n = 0;
        m_cause = 2'b00;
        m_btn_db = 1'b1;
        m_db_run = 0;
        repeat (SS) begin
            m_lock_hist.push_back(1'b0);
            m_btn_hist.push_back(1'b1);
        end

        @(negedge clk);
        tick();
        tick();
        chk("lit_reset_out", 32'(reset_out), 32'b111);
        chk("lit_reset_ready", 32'(ready), 32'd0);
        reset = 1'b0;
        repeat (4) tick();

        // clean bring-up
        lock_in = 1'b1;
        bringup_check();
        repeat (5) tick();

        // lock loss in RUN
        lock_in = 1'b0;
        tick();
        tick();
        chk("lit_loss_e2_rdy", 32'(ready), 32'd1);
        tick();
        chk("lit_loss_e3", 32'(reset_out), 32'b111);
        chk("lit_loss_e3_rdy", 32'(ready), 32'd0);
`ifdef RESET_SEQ_CAUSE_EN
        chk("lit_loss_cause", 32'(cause), 32'b01);
`endif

        // synchronous reset mid-STAGGER, then identical re-sequence
        lock_in = 1'b1;
        repeat (15) tick();
        chk("lit_mid_e15", 32'(reset_out), 32'b110);
        reset = 1'b1;
        tick();
        chk("lit_rst_out", 32'(reset_out), 32'b111);
        chk("lit_rst_rdy", 32'(ready), 32'd0);
`ifdef RESET_SEQ_CAUSE_EN
        chk("lit_rst_cause", 32'(cause), 32'b00);
`endif
        reset = 1'b0;
        bringup_check();

        // lock glitch during WAIT_LOCK restarts the full count
        lock_in = 1'b0;
        repeat (4) tick();
        lock_in = 1'b1;
        repeat (5) tick();
        lock_in = 1'b0;
        repeat (3) tick();
        lock_in = 1'b1;
        bringup_check();

        // button: short bounce ignored, long press faults
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bringup_check();
        button_n = 1'b0;
        repeat (10) tick();
        button_n = 1'b1;
        repeat (12) tick();
        chk("lit_bounce_out", 32'(reset_out), 32'b000);
        chk("lit_bounce_rdy", 32'(ready), 32'd1);
        button_n = 1'b0;
        repeat (18) tick();
        chk("lit_press_e18", 32'(reset_out), 32'b000);
        tick();
        chk("lit_press_e19", 32'(reset_out), 32'b111);
        chk("lit_press_rdy", 32'(ready), 32'd0);
`ifdef RESET_SEQ_CAUSE_EN
        chk("lit_press_cause", 32'(cause), 32'b10);
`endif
        button_n = 1'b1;
        repeat (25) tick();

        // randomized activity, rates chosen per segment
        for (int seg = 0; seg < 20; seg++) begin
            lock_rate = $urandom_range(2, 60);
            btn_rate  = $urandom_range(2, 40);
            for (int c = 0; c < 200; c++) begin
                if ($urandom_range(0, 999) < lock_rate) lock_in = ~lock_in;
                if ($urandom_range(0, 999) < btn_rate) button_n = ~button_n;
                reset = ($urandom_range(0, 999) < 3);
                tick();
            end
        end
        reset = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
